// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// MULDIV_FAST_MUL_EN: single-cycle combinational multiply path; divide timing unchanged.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic [1:0]      hilo_we,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, div_zero_q, div_zero_d;
  logic start_ok, sgn, b_zero, fast_mul, qbit;
  logic [XLEN-1:0] mag_a, mag_b, q_fix, r_fix;
  logic [XLEN:0] msum, rsh, diff;
  logic [2*XLEN-1:0] fast_prod, mul_nxt, div_nxt, prod_fix;

  assign start_ok = state_q == IDLE && start && !flush;
  assign sgn = !op[0];
  assign mag_a = sgn && a[XLEN-1] ? -a : a;
  assign mag_b = sgn && b[XLEN-1] ? -b : b;
  assign b_zero = op[1] && b == '0;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !op[1];
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
  assign fast_mul = 1'b0;
  assign fast_prod = '0;
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign msum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_nxt = {msum, acc_q[XLEN-1:1]};
  assign rsh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff = rsh - {1'b0, mcand_q};
  assign qbit = !diff[XLEN];
  assign div_nxt = {qbit ? diff[XLEN-1:0] : rsh[XLEN-1:0], acc_q[XLEN-2:0], qbit};
  assign prod_fix = qneg_q ? -acc_q : acc_q;
  assign q_fix = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign r_fix = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = (b_zero || fast_mul) ? FIX : CALC;
      CALC: state_d = flush ? IDLE : cnt_q == CW'(ITER - 1) ? FIX : CALC;
      FIX: state_d = flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = state_q == CALC || state_q == FIX;
    done = state_q == DONE;
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    is_div_d = is_div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_zero_d = div_zero_q;
    if (start_ok) begin
      cnt_d = '0;
      mcand_d = mag_b;
      is_div_d = op[1];
      dz_d = b_zero;
      qneg_d = sgn && !b_zero && (a[XLEN-1] ^ b[XLEN-1]);
      rneg_d = sgn && op[1] && !b_zero && a[XLEN-1];
      acc_d = b_zero ? {a, {XLEN{1'b1}}} : fast_mul ? fast_prod : {{XLEN{1'b0}}, mag_a};
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = is_div_q ? div_nxt : mul_nxt;
    end
    if (state_q == FIX && !flush) begin
      {hi_d, lo_d} = is_div_q ? {r_fix, q_fix} : prod_fix;
      div_zero_d = is_div_q ? dz_q : div_zero_q;
    end else if (state_q == IDLE || state_q == DONE) begin
      hi_d = hilo_we[1] ? hilo_wdata : hi_q;
      lo_d = hilo_we[0] ? hilo_wdata : lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      is_div_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      is_div_q <= is_div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst, start, flush, busy, done, div_zero;
  logic [1:0] op, hilo_we;
  logic [31:0] a, b, hilo_wdata, hi, lo;
  int checks = 0, failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic m_dz = 1'b0;
  bit fast = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] ux, uy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (o[1] && y == 32'h0) return {x, 32'hFFFF_FFFF};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: begin q = ux / uy; r = ux % uy; return {r[31:0], q[31:0]}; end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] y);
    return ((o[1] && y == 32'h0) || (fast && !o[1])) ? 2 : 34;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    logic [31:0] chi, clo;
    int lat, bad, done_at;
    e = ref_res(o, x, y);
    lat = lat_of(o, y);
    bad = 0;
    done_at = 0;
    chi = '0;
    clo = '0;
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      if (k > 1) tick;
      if (busy !== (k < lat)) bad++;
      if (done !== (k == lat)) bad++;
      if (done === 1'b1 && done_at == 0) done_at = k;
      if (k == lat) begin chi = hi; clo = lo; end
    end
    m_hi = e[63:32];
    m_lo = e[31:0];
    if (o[1]) m_dz = (y == 32'h0);
    check({tag, ".done_at"}, done_at, lat);
    check({tag, ".busy_done_shape"}, bad, 0);
    check({tag, ".hi"}, chi, m_hi);
    check({tag, ".lo"}, clo, m_lo);
    check({tag, ".div_zero"}, div_zero, m_dz);
  endtask

  task automatic hilo_write(input logic [1:0] we, input logic [31:0] d);
    hilo_we = we; hilo_wdata = d;
    tick;
    hilo_we = 2'b00;
    if (we[1]) m_hi = d;
    if (we[0]) m_lo = d;
    check("hilo_write.hi", hi, m_hi);
    check("hilo_write.lo", lo, m_lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, n_busy, r;
    logic [1:0] o;
    logic [31:0] x, y;
`ifdef MULDIV_FAST_MUL_EN
    fast = 1'b1;
`endif
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    hilo_we = 2'b00; hilo_wdata = '0;
    repeat (3) tick;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.div_zero", div_zero, 0);
    check("reset.hi", hi, 0);
    check("reset.lo", lo, 0);
    rst = 1'b0;
    tick;

    run_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_5_0", 2'b10, 32'd5, 32'd0);
    run_op("mult_keeps_dz", 2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op("divu_9_3", 2'b11, 32'd9, 32'd3);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_neg", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    hilo_write(2'b11, 32'h1234_5678);
    hilo_write(2'b10, 32'hCAFE_F00D);
    hilo_write(2'b01, 32'h0BAD_BEEF);

    // start asserted during DONE must not relaunch
    op = 2'b11; a = 32'd50; b = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (33) tick;
    check("done_start.done", done, 1);
    m_hi = 32'd0; m_lo = 32'd10; m_dz = 1'b0;
    op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    check("done_start.busy", busy, 0);
    tick;
    check("done_start.busy2", busy, 0);
    check("done_start.lo", lo, m_lo);

    // flush mid-divide, with an ignored start and an ignored hilo write while busy
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    hilo_we = 2'b11; hilo_wdata = 32'hDEAD_BEEF;
    tick;
    hilo_we = 2'b00;
    tick;
    op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    check("flush.busy_after_start", busy, 1);
    repeat (4) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush.busy", busy, 0);
    check("flush.done", done, 0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (done === 1'b1) n_done++;
    end
    check("flush.no_done", n_done, 0);
    check("flush.hi", hi, m_hi);
    check("flush.lo", lo, m_lo);

    // start with flush in IDLE is dropped
    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    n_busy = 0; n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) n_done++;
      tick;
    end
    check("start_flush.busy", n_busy, 0);
    check("start_flush.done", n_done, 0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      r = $urandom_range(0, 9);
      y = r == 0 ? 32'h0 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'($urandom_range(1, 15)) : $urandom;
      if (r == 1) x = 32'h8000_0000;
      run_op("rand", o, x, y);
      if ($urandom_range(0, 3) == 0) hilo_write(2'($urandom_range(1, 3)), $urandom);
    end

    // reset mid-divide with sticky div_zero set
    run_op("pre_rst_dz", 2'b11, 32'd77, 32'd0);
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (19) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst.busy", busy, 0);
    check("mid_rst.done", done, 0);
    check("mid_rst.div_zero", div_zero, 0);
    check("mid_rst.hi", hi, 0);
    check("mid_rst.lo", lo, 0);
    repeat (3) tick;
    check("mid_rst.idle", busy, 0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    run_op("post_rst", 2'b10, 32'hFFFF_FFF9, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
